ar_rr_arbiter: RTL and testbench
================================

// Module: ar_rr_arbiter
// PURPOSE
// - Shares one AXI4 AR master channel among NUM_REQ read engines (each an AR-channel source).
// - Round-robin arbitration; winner's request is registered, then issued on the master port.
// - Tags each request with its requester index as ARID.
// - Caps in-flight bursts per requester by snooping R-channel RLAST beats.
// PARAMETERS
// - NUM_REQ          2   number of requesters (>=2)
// - AXI_ADDR_WIDTH  64   araddr width
// - AXI_ID_WIDTH     4   arid/rid width; must be >= $clog2(NUM_REQ)
// - MAX_OUTSTANDING  8   max in-flight bursts per requester (>=1)
// PORTS
// - clk           in   1                    clock, all logic posedge
// - rst           in   1                    synchronous, active-high reset
// - req_arvalid   in   NUM_REQ              per-requester AR valid
// - req_arready   out  NUM_REQ              per-requester AR ready (one-hot or zero)
// - req_araddr    in   NUM_REQ*ADDR_WIDTH   packed, requester i at [i*AW +: AW]
// - req_arlen     in   NUM_REQ*8            packed, requester i at [i*8 +: 8]
// - req_idle      out  NUM_REQ              1 when requester i has 0 outstanding bursts
// - m_arvalid     out  1                    master AR valid
// - m_arready     in   1                    master AR ready
// - m_araddr      out  AXI_ADDR_WIDTH       registered address
// - m_arlen       out  8                    registered burst length
// - m_arid        out  AXI_ID_WIDTH         winner index, zero-extended
// - m_arsize      out  3                    constant 3'b100 (16 B)
// - m_arburst     out  2                    constant 2'b01 (INCR)
// - m_rvalid, m_rready, m_rlast  in  1 each R-channel snoop (observation only)
// - m_rid         in   AXI_ID_WIDTH         R-channel ID snoop
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; m_arvalid=0; req_arready=0.
//   - m_araddr/m_arlen/m_arid=0; all counters 0; rr pointer=0; req_idle all 1.
// - Eligibility: elig[i] = req_arvalid[i] && cnt[i] < MAX_OUTSTANDING.
// - State IDLE:
//   - If any elig: pick the first eligible i scanning ptr, ptr+1, ... mod NUM_REQ.
//   - req_arready[i]=1 combinationally in that cycle; latch addr/len; arid=i.
//   - Set ptr = (i+1) mod NUM_REQ; cnt[i]++; go to SEND.
// - State SEND:
//   - m_arvalid=1; payload stable until m_arready.
//   - On m_arready go to IDLE.
//   - Throughput is 1 grant / 2 cycles minimum.
// - req_arready is 0 in SEND and when nothing is eligible.
// - Decrement: cnt[k]-- on m_rvalid && m_rready && m_rlast && m_rid==k.
//   - m_rid >= NUM_REQ: ignored.
//   - cnt[k]==0: ignored (no underflow).
// - Same-cycle increment and decrement of the same cnt: value unchanged.
// - Counter width: $clog2(MAX_OUTSTANDING+1).
// - cnt==MAX: requester masked, no stall of others; it re-enters arbitration the cycle after its decrement.
// - req_idle[i] = (cnt[i]==0), registered-counter based.
// - A requester must hold req_arvalid/addr/len until req_arready (AXI rule).
// - Reset mid-SEND: m_arvalid drops next edge; counters cleared (system reset only).
// CONFIGURATION
// - AR_ARB_STATS_EN defined:
//   - Adds output grant_cnt, NUM_REQ*32 packed: a per-requester count of req handshakes.
//   - Counters wrap at 2^32; reset 0.
// - AR_ARB_STATS_EN undefined:
//   - Port and counters absent; all other behaviour identical.
// TESTING
// - Single req0 (addr 0x1000, len 7), m_arready=1 -> req_arready[0] cycle 0; m_arvalid cycle 1 with addr 0x1000, len 7, arid 0.
// - req0, req1 both always valid, m_arready=1 -> grant order 0,1,0,1; one AR every 2 cycles.
// - MAX_OUTSTANDING=2, req0 valid, no R beats -> exactly 2 grants, then req_arready[0] stays 0.
//   - One RLAST with rid=0 -> a 3rd grant follows.
// - m_arready=0 for 5 cycles in SEND -> m_arvalid/addr/len/id stable, no req_arready; handshake on cycle 6.
// - Same cycle: req0 accept plus RLAST rid=0 at cnt=1 -> cnt stays 1.
//   - RLAST with rid=3 (NUM_REQ=2) or at cnt=0 -> no change.
// - rst asserted during SEND -> next cycle m_arvalid=0, req_idle all 1.
//   - With AR_ARB_STATS_EN: grant_cnt=0.

Source files
------------

// File: rtl/ar_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 AR master channel among NUM_REQ read engines,
// with a per-requester in-flight burst cap tracked by snooping RLAST. Define AR_ARB_STATS_EN for grant_cnt.
module ar_rr_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned AXI_ADDR_WIDTH  = 64,
  parameter int unsigned AXI_ID_WIDTH    = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_arvalid,
  output logic [NUM_REQ-1:0]                  req_arready,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_araddr,
  input  logic [NUM_REQ*8-1:0]                req_arlen,
  output logic [NUM_REQ-1:0]                  req_idle,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [AXI_ADDR_WIDTH-1:0]           m_araddr,
  output logic [7:0]                          m_arlen,
  output logic [AXI_ID_WIDTH-1:0]             m_arid,
  output logic [2:0]                          m_arsize,
  output logic [1:0]                          m_arburst,
  input  logic                                m_rvalid,
  input  logic                                m_rready,
  input  logic                                m_rlast,
  input  logic [AXI_ID_WIDTH-1:0]             m_rid
`ifdef AR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]               grant_cnt
`endif
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [CW-1:0]             cnt_q [NUM_REQ];
  logic [CW-1:0]             cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0]        elig;
  logic [2*NUM_REQ-1:0]      elig_rot;
  logic                      grant_vld;
  logic [PW-1:0]             win;
  logic                      r_last_beat;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_arvalid[i] && (cnt_q[i] < MAX_C);
    end
  end

  // Rotating the doubled request vector right by ptr puts the highest-priority requester at bit 0.
  always_comb begin
    int unsigned sum;
    sum       = 0;
    grant_vld = 1'b0;
    win       = '0;
    elig_rot  = {elig, elig} >> ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && elig_rot[i]) begin
        grant_vld = 1'b1;
        sum       = (32'(ptr_q) + i) % NUM_REQ;
        win       = PW'(sum);
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt         = 0;
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    req_arready = '0;
    m_arvalid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_arready[win] = 1'b1;
          addr_d  = req_araddr[32'(win)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          len_d   = req_arlen[32'(win)*8 +: 8];
          id_d    = AXI_ID_WIDTH'(win);
          nxt     = (32'(win) + 1) % NUM_REQ;
          ptr_d   = PW'(nxt);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign r_last_beat = m_rvalid && m_rready && m_rlast;

  // Simultaneous grant and RLAST for the same requester cancel out; a decrement at zero is dropped.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc      = req_arready[i];
      dec      = r_last_beat && (m_rid == AXI_ID_WIDTH'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    req_idle = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_idle[i] = (cnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arid    = id_q;
  assign m_arsize  = 3'b100;
  assign m_arburst = 2'b01;

`ifdef AR_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_REQ];
  logic [31:0] gcnt_d [NUM_REQ];

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gcnt_d[i] = gcnt_q[i] + (req_arready[i] ? 32'd1 : 32'd0);
      grant_cnt[i*32 +: 32] = gcnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        gcnt_q[i] <= '0;
      end else begin
        gcnt_q[i] <= gcnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ar_rr_arbiter.sv
// Directed bench for ar_rr_arbiter (NUM_REQ=2, MAX_OUTSTANDING=2) with an AR-payload scoreboard.
module tb_ar_rr_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_arvalid;
  logic [NR-1:0]   req_arready;
  logic [NR*AW-1:0] req_araddr;
  logic [NR*8-1:0] req_arlen;
  logic [NR-1:0]   req_idle;
  logic            m_arvalid;
  logic            m_arready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [IW-1:0]   m_arid;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_rvalid;
  logic            m_rready;
  logic            m_rlast;
  logic [IW-1:0]   m_rid;
`ifdef AR_ARB_STATS_EN
  logic [NR*32-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  ar_rr_arbiter #(
    .NUM_REQ        (NR),
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_arvalid(req_arvalid),
    .req_arready(req_arready),
    .req_araddr (req_araddr),
    .req_arlen  (req_arlen),
    .req_idle   (req_idle),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arid     (m_arid),
    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rlast    (m_rlast),
    .m_rid      (m_rid)
`ifdef AR_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned g0 = 0;
  int unsigned g1 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the falling edge and retires any AR handshake against the scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (!rst && m_arvalid && m_arready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ar", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_addr", m_araddr, e.addr);
        check("sb_len", {56'd0, m_arlen}, {56'd0, e.len});
        check("sb_id", {60'd0, m_arid}, {60'd0, e.id});
        check("sb_size", {61'd0, m_arsize}, 64'd4);
        check("sb_burst", {62'd0, m_arburst}, 64'd1);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [7:0] l, input logic [3:0] id);
    exp_t e;
    e.addr = a;
    e.len  = l;
    e.id   = id;
    sb.push_back(e);
    if (id == 4'd0) g0++; else g1++;
  endtask

  task automatic set_req(input int i, input logic v, input logic [63:0] a, input logic [7:0] l);
    req_arvalid[i]       = v;
    req_araddr[i*64 +: 64] = a;
    req_arlen[i*8 +: 8]  = l;
  endtask

  task automatic rlast_on(input logic [3:0] id);
    m_rvalid = 1'b1;
    m_rready = 1'b1;
    m_rlast  = 1'b1;
    m_rid    = id;
  endtask

  task automatic rlast_off();
    m_rvalid = 1'b0;
    m_rready = 1'b0;
    m_rlast  = 1'b0;
    m_rid    = '0;
  endtask

  task automatic rlast_pulse(input logic [3:0] id);
    rlast_on(id);
    sample();
    adv();
    rlast_off();
  endtask

  logic [1:0] rdy_pat [10];
  logic       exp_v;

  initial begin
    rdy_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    rst = 1'b1;
    req_arvalid = '0;
    req_araddr  = '0;
    req_arlen   = '0;
    m_arready   = 1'b0;
    rlast_off();
    adv();
    adv();

    sample();
    check("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
    check("rst_arready", {62'd0, req_arready}, 64'd0);
    check("rst_idle", {62'd0, req_idle}, 64'd3);
    check("rst_addr", m_araddr, 64'd0);
    check("rst_len", {56'd0, m_arlen}, 64'd0);
    check("rst_id", {60'd0, m_arid}, 64'd0);
    rst = 1'b0;
    adv();

    // Single requester: grant in cycle 0, AR issued in cycle 1.
    set_req(0, 1'b1, 64'h1000, 8'd7);
    m_arready = 1'b1;
    sample();
    check("t1_grant", {62'd0, req_arready}, 64'd1);
    check("t1_arvalid0", {63'd0, m_arvalid}, 64'd0);
    push(64'h1000, 8'd7, 4'd0);
    adv();
    req_arvalid[0] = 1'b0;
    sample();
    check("t1_arvalid1", {63'd0, m_arvalid}, 64'd1);
    check("t1_rdy_send", {62'd0, req_arready}, 64'd0);
    check("t1_idle_busy", {62'd0, req_idle}, 64'd2);
    adv();
    rlast_pulse(4'd0);
    sample();
    check("t1_idle_back", {62'd0, req_idle}, 64'd3);
    adv();

    // Fresh reset so the pointer starts at 0, then both requesters contend until capped.
    rst = 1'b1;
    adv();
    rst = 1'b0;
    g0 = 0;
    g1 = 0;
    set_req(0, 1'b1, 64'h2000, 8'd1);
    set_req(1, 1'b1, 64'h3000, 8'd3);
    m_arready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      exp_v = (c % 2 == 1) && (c < 8);
      check("t2_rr_grant", {62'd0, req_arready}, {62'd0, rdy_pat[c]});
      check("t2_arvalid", {63'd0, m_arvalid}, {63'd0, exp_v});
      if (rdy_pat[c] == 2'b01) push(64'h2000, 8'd1, 4'd0);
      else if (rdy_pat[c] == 2'b10) push(64'h3000, 8'd3, 4'd1);
      adv();
    end
    sample();
    check("t2_idle_capped", {62'd0, req_idle}, 64'd0);
    check("t2_no_grant_capped", {62'd0, req_arready}, 64'd0);
`ifdef AR_ARB_STATS_EN
    check("t2_grant_cnt", grant_cnt, {g1, g0});
`endif
    adv();

    // RLAST for requester 0 lets it back in the following cycle.
    rlast_on(4'd0);
    sample();
    check("t3_rdy_during_dec", {62'd0, req_arready}, 64'd0);
    adv();
    rlast_off();
    sample();
    check("t3_reenter", {62'd0, req_arready}, 64'd1);
    push(64'h2000, 8'd1, 4'd0);
    adv();
    req_arvalid[0] = 1'b0;
    sample();
    check("t3_arvalid", {63'd0, m_arvalid}, 64'd1);
    adv();
    rlast_pulse(4'd3);
    sample();
    check("t3_rid_oob_rdy", {62'd0, req_arready}, 64'd0);
    check("t3_rid_oob_idle", {62'd0, req_idle}, 64'd0);
    adv();
    req_arvalid = '0;
    rlast_pulse(4'd0);
    rlast_pulse(4'd0);
    rlast_pulse(4'd1);
    rlast_pulse(4'd1);
    sample();
    check("t3_drained", {62'd0, req_idle}, 64'd3);
    adv();
    rlast_pulse(4'd0);
    sample();
    check("t3_no_underflow", {62'd0, req_idle}, 64'd3);
    adv();

    // Backpressure: payload holds for 5 stalled cycles, handshake on the 6th.
    set_req(0, 1'b1, 64'h4000, 8'h0f);
    m_arready = 1'b0;
    sample();
    check("t4_grant", {62'd0, req_arready}, 64'd1);
    push(64'h4000, 8'h0f, 4'd0);
    adv();
    set_req(0, 1'b1, 64'h4444, 8'd9);
    set_req(1, 1'b1, 64'h5000, 8'd2);
    for (int k = 0; k < 5; k++) begin
      sample();
      check("t4_hold_vld", {63'd0, m_arvalid}, 64'd1);
      check("t4_hold_addr", m_araddr, 64'h4000);
      check("t4_hold_len", {56'd0, m_arlen}, 64'h0f);
      check("t4_hold_id", {60'd0, m_arid}, 64'd0);
      check("t4_hold_rdy", {62'd0, req_arready}, 64'd0);
      adv();
    end
    m_arready = 1'b1;
    req_arvalid[0] = 1'b0;
    sample();
    check("t4_hs_rdy", {62'd0, req_arready}, 64'd0);
    adv();
    sample();
    check("t4_next_rr", {62'd0, req_arready}, 64'd2);
    push(64'h5000, 8'd2, 4'd1);
    adv();
    req_arvalid = '0;
    sample();
    adv();

    // Grant and RLAST for the same requester in one cycle leave its count at 1.
    set_req(0, 1'b1, 64'h6000, 8'd5);
    rlast_on(4'd0);
    sample();
    check("t5_grant", {62'd0, req_arready}, 64'd1);
    push(64'h6000, 8'd5, 4'd0);
    adv();
    rlast_off();
    req_arvalid = '0;
    sample();
    check("t5_cnt_kept", {62'd0, req_idle}, 64'd0);
    adv();
    rlast_pulse(4'd0);
    sample();
    check("t5_cnt_was_one", {62'd0, req_idle}, 64'd1);
    adv();
    rlast_pulse(4'd1);
    sample();
    check("t5_all_idle", {62'd0, req_idle}, 64'd3);
    adv();

    // Reset while an AR is pending on the master port.
    set_req(0, 1'b1, 64'h7000, 8'd1);
    m_arready = 1'b0;
    sample();
    check("t6_grant", {62'd0, req_arready}, 64'd1);
    g0++;
    adv();
    req_arvalid = '0;
    sample();
    check("t6_send", {63'd0, m_arvalid}, 64'd1);
`ifdef AR_ARB_STATS_EN
    check("t6_grant_cnt_pre", grant_cnt, {g1, g0});
`endif
    rst = 1'b1;
    adv();
    sample();
    check("t6_rst_arvalid", {63'd0, m_arvalid}, 64'd0);
    check("t6_rst_idle", {62'd0, req_idle}, 64'd3);
    check("t6_rst_addr", m_araddr, 64'd0);
    check("t6_rst_rdy", {62'd0, req_arready}, 64'd0);
`ifdef AR_ARB_STATS_EN
    check("t6_rst_grant_cnt", grant_cnt, 64'd0);
`endif
    rst = 1'b0;
    adv();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
